// File: rtl/isa_pkg.sv
// Instruction-word format shared by the loader (encode side) and decode-side checks.
// Opcodes, field positions/widths, the loader FSM state type and the field encoder.
package isa_pkg;

  localparam int OP_W    = 4;
  localparam int REG_W   = 5;
  localparam int FUNC_W  = 4;
  localparam int IMM_W   = 16;
  localparam int INSTR_W = 32;

  localparam int OP_LSB   = 28;
  localparam int RS_LSB   = 23;
  localparam int RT_LSB   = 18;
  localparam int RD_LSB   = 13;
  localparam int FUNC_LSB = 0;
  localparam int IMM_LSB  = 0;

  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_LW  = 4'd2;
  localparam logic [OP_W-1:0] OP_SW  = 4'd3;
  localparam logic [OP_W-1:0] OP_BEQ = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } loaderState_t;

  function automatic logic isLegalOp(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_LW, OP_SW, OP_BEQ};
  endfunction

  // Unknown opcodes encode to the all-zero NOP word the EX controller decodes by default.
  function automatic logic [INSTR_W-1:0] encodeInstr(
    input logic [OP_W-1:0]   op,
    input logic [REG_W-1:0]  rs,
    input logic [REG_W-1:0]  rt,
    input logic [REG_W-1:0]  rd,
    input logic [FUNC_W-1:0] func,
    input logic [IMM_W-1:0]  imm
  );
    logic [INSTR_W-1:0] word;
    word = '0;
    case (op)
      OP_ADD: begin
        word[OP_LSB +: OP_W]     = op;
        word[RS_LSB +: REG_W]    = rs;
        word[RT_LSB +: REG_W]    = rt;
        word[RD_LSB +: REG_W]    = rd;
        word[FUNC_LSB +: FUNC_W] = func;
      end
      OP_LW, OP_SW, OP_BEQ: begin
        word[OP_LSB +: OP_W]   = op;
        word[RS_LSB +: REG_W]  = rs;
        word[RT_LSB +: REG_W]  = rt;
        word[IMM_LSB +: IMM_W] = imm;
      end
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// DEPTH x WIDTH synchronous FIFO with occupancy count; DEPTH must be a power of two.
// Caller guarantees no pop when empty; push while full is legal only together with a pop.
module loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  assign popData = mem[rdPtr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/instr_mem_loader.sv
// Encodes instruction fields, buffers them and writes them sequentially to instruction memory.
// Optional macro LOADER_ILLEGAL_OP_TRAP_EN: drop illegal opcodes and raise sticky err.
module instr_mem_loader
  import isa_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  word_cnt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [REG_W-1:0]   in_rs,
  input  logic [REG_W-1:0]   in_rt,
  input  logic [REG_W-1:0]   in_rd,
  input  logic [FUNC_W-1:0]  in_func,
  input  logic [IMM_W-1:0]   in_imm,
  output logic               imem_req,
  input  logic               imem_gnt,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               done,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = $clog2(DEPTH+1);

  loaderState_t       state;
  logic [ADDR_W-1:0]  remaining;
  logic [INSTR_W-1:0] encWord;
  logic [INSTR_W-1:0] headWord;
  logic [CNT_W-1:0]   fifoCount;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               accept;
  logic               push;
  logic               pop;

  assign encWord  = encodeInstr(in_op, in_rs, in_rt, in_rd, in_func, in_imm);
  assign pop      = imem_req && imem_gnt;
  // Words already buffered are owed to memory, so only (remaining - occupancy) more may enter.
  assign in_ready = (state == ST_LOAD) && (!fifoFull || pop) &&
                    (remaining > ADDR_W'(fifoCount));
  assign accept   = in_valid && in_ready;

`ifdef LOADER_ILLEGAL_OP_TRAP_EN
  logic legalOp;
  assign legalOp = isLegalOp(in_op);
  assign push    = accept && legalOp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err <= 1'b0;
    else if (accept && !legalOp) err <= 1'b1;
  end
`else
  assign push = accept;
  assign err  = 1'b0;
`endif

  loader_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pushData (encWord),
    .pop      (pop),
    .popData  (headWord),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign imem_req   = (state == ST_LOAD) && !fifoEmpty;
  assign imem_wdata = imem_req ? headWord : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      imem_addr <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            imem_addr <= base_addr;
            remaining <= word_cnt;
            if (word_cnt == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_LOAD;
              busy  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (pop) begin
            imem_addr <= imem_addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
